// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
//  Shared types and helpers for the stream width converters.
//  - stream_ds_state_t : downsizer FSM state encoding (IDLE / SEND)
//  - STREAM_MAX_RATIO  : widest lane mask the helper function accepts
//  - STREAM_LANE_IDX_W : lane-index width for the widest mask
//  - stream_lowest_set : index of the lowest set bit of a lane mask
// -----------------------------------------------------------------------------
package stream_pkg;

  localparam int STREAM_MAX_RATIO  = 32;
  localparam int STREAM_LANE_IDX_W = $clog2(STREAM_MAX_RATIO);

  typedef enum logic {ST_IDLE, ST_SEND} stream_ds_state_t;

  // Returns 0 for an all-zero mask; callers qualify with their own
  // "mask non-empty" condition.
  function automatic logic [STREAM_LANE_IDX_W-1:0] stream_lowest_set(
    input logic [STREAM_MAX_RATIO-1:0] mask
  );
    logic [STREAM_LANE_IDX_W-1:0] idx;
    idx = '0;
    for (int i = STREAM_MAX_RATIO - 1; i >= 0; i--) begin
      if (mask[i]) idx = STREAM_LANE_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/stream_lane_pick.sv
// -----------------------------------------------------------------------------
// stream_lane_pick
//  Combinational priority encoder over a lane mask.
//  Ports:
//    mask_i      : remaining-lane mask
//    idx_o       : index of the lowest set lane
//    clr_o       : one-hot mask of that lane (used to retire it)
//    last_lane_o : mask has exactly one bit set
// -----------------------------------------------------------------------------
module stream_lane_pick
  import stream_pkg::*;
#(
  parameter  int T_DATA_RATIO = 2,
  localparam int IDX_W        = $clog2(T_DATA_RATIO)
) (
  input  logic [T_DATA_RATIO-1:0] mask_i,
  output logic [IDX_W-1:0]        idx_o,
  output logic [T_DATA_RATIO-1:0] clr_o,
  output logic                    last_lane_o
);

  logic [STREAM_LANE_IDX_W-1:0] low_idx;

  always_comb begin
    low_idx     = stream_lowest_set(STREAM_MAX_RATIO'(mask_i));
    idx_o       = IDX_W'(low_idx);
    clr_o       = '0;
    clr_o[idx_o] = 1'b1;
    // x & (x-1) clears the lowest set bit; zero result means one bit left.
    last_lane_o = (mask_i != '0) &&
                  ((mask_i & (mask_i - T_DATA_RATIO'(1))) == '0);
  end

endmodule

// File: rtl/stream_downsize.sv
// -----------------------------------------------------------------------------
// stream_downsize
//  Wide-to-narrow stream converter. Each accepted wide word (lane array plus
//  keep mask) is serialized onto a single-lane stream, kept lanes only, in
//  ascending lane order. Words with an empty keep mask are dropped.
//
//  Handshake: a transfer happens on a rising edge where valid && ready are
//  both high; valid never drops without a transfer and the beat payload is
//  held stable while valid && !ready.
//
//  Ports:
//    clk, rst_n   : clock, asynchronous active-low reset
//    s_data_i     : wide word, unpacked lane array [T_DATA_RATIO-1:0]
//    s_keep_i     : per-lane keep mask
//    s_last_i     : word ends the packet
//    s_valid_i    : wide word valid
//    s_ready_o    : wide word ready (no dependency on s_valid_i)
//    m_data_o     : narrow beat
//    m_last_o     : final beat of the packet
//    m_valid_o    : narrow beat valid
//    m_ready_i    : downstream ready
//    err_o        : sticky keep-mask error (only with STREAM_DOWNSIZE_KEEP_CHECK_EN)
//
//  Build option: define STREAM_DOWNSIZE_KEEP_CHECK_EN to add err_o, set when
//  an accepted word has an empty or non-contiguous (not 2^k-1) keep mask.
// -----------------------------------------------------------------------------
module stream_downsize
  import stream_pkg::*;
#(
  parameter  int T_DATA_WIDTH = 4,
  parameter  int T_DATA_RATIO = 2,
  localparam int IDX_W        = $clog2(T_DATA_RATIO)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
  ,output logic                   err_o
`endif
);

  stream_ds_state_t        state_q, state_d;
  logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO-1:0];
  logic [T_DATA_WIDTH-1:0] data_d [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] rem_q, rem_d;
  logic                    last_q, last_d;

  logic [IDX_W-1:0]        pick_idx;
  logic [T_DATA_RATIO-1:0] pick_clr;
  logic                    pick_last_lane;

  logic                    send;
  logic                    accept;
  logic                    keep_nz;

  stream_lane_pick #(
    .T_DATA_RATIO (T_DATA_RATIO)
  ) u_lane_pick (
    .mask_i      (rem_q),
    .idx_o       (pick_idx),
    .clr_o       (pick_clr),
    .last_lane_o (pick_last_lane)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    last_d  = last_q;

    send    = (state_q == ST_SEND);
    keep_nz = (s_keep_i != '0);
    // rst_n gates ready so nothing is accepted while reset is held.
    s_ready_o = rst_n && (!send || (m_ready_i && pick_last_lane));
    accept    = s_valid_i && s_ready_o;

    case (state_q)
      ST_IDLE: begin
        if (accept && keep_nz) begin
          data_d  = s_data_i;
          rem_d   = s_keep_i;
          last_d  = s_last_i;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_ready_i) begin
          rem_d = rem_q & ~pick_clr;
          // Completing beat: reload back-to-back or fall back to IDLE.
          if (pick_last_lane) begin
            if (accept && keep_nz) begin
              data_d = s_data_i;
              rem_d  = s_keep_i;
              last_d = s_last_i;
            end else begin
              last_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    m_valid_o = send;
    m_data_o  = send ? data_q[pick_idx] : '0;
    m_last_o  = send && last_q && pick_last_lane;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
  logic err_q, err_d;

  // Contiguous-from-lane-0 masks are 2^k-1: adding one clears every set bit.
  always_comb begin
    err_d = err_q;
    if (accept &&
        (!keep_nz || ((s_keep_i & (s_keep_i + T_DATA_RATIO'(1))) != '0))) begin
      err_d = 1'b1;
    end
    err_o = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_stream_downsize.sv
// -----------------------------------------------------------------------------
// tb_stream_downsize
//  Directed bench for stream_downsize. Two instances share clk/rst_n:
//  u2 (RATIO=2, W=4) and u4 (RATIO=4, W=4). Inputs are driven 1 time unit
//  after the rising edge; outputs are sampled on the falling edge and 1 time
//  unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_downsize;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [3:0] u2_s_data [1:0];
  logic [1:0] u2_s_keep;
  logic       u2_s_last, u2_s_valid, u2_s_ready;
  logic [3:0] u2_m_data;
  logic       u2_m_last, u2_m_valid, u2_m_ready;

  logic [3:0] u4_s_data [3:0];
  logic [3:0] u4_s_keep;
  logic       u4_s_last, u4_s_valid, u4_s_ready;
  logic [3:0] u4_m_data;
  logic       u4_m_last, u4_m_valid, u4_m_ready;

`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
  logic u2_err, u4_err;
`endif

  stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) u2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (u2_s_data),
    .s_keep_i  (u2_s_keep),
    .s_last_i  (u2_s_last),
    .s_valid_i (u2_s_valid),
    .s_ready_o (u2_s_ready),
    .m_data_o  (u2_m_data),
    .m_last_o  (u2_m_last),
    .m_valid_o (u2_m_valid),
    .m_ready_i (u2_m_ready)
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
    ,.err_o    (u2_err)
`endif
  );

  stream_downsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(4)) u4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (u4_s_data),
    .s_keep_i  (u4_s_keep),
    .s_last_i  (u4_s_last),
    .s_valid_i (u4_s_valid),
    .s_ready_o (u4_s_ready),
    .m_data_o  (u4_m_data),
    .m_last_o  (u4_m_last),
    .m_valid_o (u4_m_valid),
    .m_ready_i (u4_m_ready)
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
    ,.err_o    (u4_err)
`endif
  );

  // ---------------- scoreboard ----------------
  int         n_checks;
  int         n_fail;
  logic [4:0] exp2_q[$];     // {last, data}
  logic [4:0] exp4_q[$];
  int         beat_cyc_q[$]; // cycle stamps of u2 beats
  logic       prev_stall2;
  logic [4:0] prev_beat2;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Beats are compared on the falling edge before the edge that transfers them.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall2 = 1'b0;
    end else begin
      if (prev_stall2) begin
        check_eq("u2_hold_valid", 32'(u2_m_valid), 32'd1);
        check_eq("u2_hold_beat", 32'({u2_m_last, u2_m_data}), 32'(prev_beat2));
      end
      if (u2_m_valid && u2_m_ready) begin
        beat_cyc_q.push_back(cyc);
        check_eq("u2_beat_expected", 32'(exp2_q.size() != 0), 32'd1);
        if (exp2_q.size() != 0)
          check_eq("u2_beat", 32'({u2_m_last, u2_m_data}), 32'(exp2_q.pop_front()));
      end
      if (u4_m_valid && u4_m_ready) begin
        check_eq("u4_beat_expected", 32'(exp4_q.size() != 0), 32'd1);
        if (exp4_q.size() != 0)
          check_eq("u4_beat", 32'({u4_m_last, u4_m_data}), 32'(exp4_q.pop_front()));
      end
      prev_stall2 = u2_m_valid && !u2_m_ready;
      prev_beat2  = {u2_m_last, u2_m_data};
    end
  end

  // ---------------- driver tasks ----------------
  // Present a word and hold it until accepted; returns cycles taken.
  task automatic send2(input logic [7:0] lanes, input logic [1:0] keep,
                       input logic last, output int ncyc);
    logic acc;
    acc = 1'b0;
    ncyc = 0;
    u2_s_data[0] = lanes[3:0];
    u2_s_data[1] = lanes[7:4];
    u2_s_keep    = keep;
    u2_s_last    = last;
    u2_s_valid   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = u2_s_ready;
      @(posedge clk);
      #1;
      ncyc++;
      if (acc) break;
    end
    check_eq("u2_accept", 32'(acc), 32'd1);
  endtask

  task automatic send4(input logic [15:0] lanes, input logic [3:0] keep,
                       input logic last, output int ncyc);
    logic acc;
    acc = 1'b0;
    ncyc = 0;
    for (int l = 0; l < 4; l++) u4_s_data[l] = lanes[l*4 +: 4];
    u4_s_keep  = keep;
    u4_s_last  = last;
    u4_s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = u4_s_ready;
      @(posedge clk);
      #1;
      ncyc++;
      if (acc) break;
    end
    check_eq("u4_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle2();
    u2_s_valid = 1'b0;
    u2_s_keep  = '0;
    u2_s_last  = 1'b0;
  endtask

  task automatic idle4();
    u4_s_valid = 1'b0;
    u4_s_keep  = '0;
    u4_s_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until every expected beat has been transferred.
  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp2_q.size() == 0 && exp4_q.size() == 0) break;
      step();
    end
    check_eq("drain_u2_empty", 32'(exp2_q.size()), 32'd0);
    check_eq("drain_u4_empty", 32'(exp4_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic tog_on;
  int   nc;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    tog_on   = 1'b0;
    prev_stall2 = 1'b0;
    prev_beat2  = '0;
    rst_n = 1'b0;
    u2_m_ready = 1'b1;
    u4_m_ready = 1'b1;
    u2_s_data[0] = '0; u2_s_data[1] = '0;
    for (int l = 0; l < 4; l++) u4_s_data[l] = '0;
    idle2();
    idle4();

    // Reset state
    repeat (2) step();
    check_eq("rst_u2_m_valid", 32'(u2_m_valid), 32'd0);
    check_eq("rst_u2_m_last",  32'(u2_m_last),  32'd0);
    check_eq("rst_u2_m_data",  32'(u2_m_data),  32'd0);
    check_eq("rst_u2_s_ready", 32'(u2_s_ready), 32'd0);
    check_eq("rst_u4_m_valid", 32'(u4_m_valid), 32'd0);
    check_eq("rst_u4_s_ready", 32'(u4_s_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("idle_u2_s_ready", 32'(u2_s_ready), 32'd1);
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
    check_eq("rst_u2_err", 32'(u2_err), 32'd0);
`endif
    step();

    // 1: {B,A}, keep 11, last -> A then B(last); ready high in B's cycle
    exp2_q.push_back({1'b0, 4'hA});
    exp2_q.push_back({1'b1, 4'hB});
    send2(8'hBA, 2'b11, 1'b1, nc);
    idle2();
    check_eq("t1_valid_a", 32'(u2_m_valid), 32'd1);
    check_eq("t1_data_a",  32'(u2_m_data),  32'hA);
    check_eq("t1_last_a",  32'(u2_m_last),  32'd0);
    check_eq("t1_sready_a", 32'(u2_s_ready), 32'd0);
    step();
    check_eq("t1_data_b",  32'(u2_m_data),  32'hB);
    check_eq("t1_last_b",  32'(u2_m_last),  32'd1);
    check_eq("t1_sready_b", 32'(u2_s_ready), 32'd1);
    step();
    check_eq("t1_valid_end", 32'(u2_m_valid), 32'd0);
    drain(10);

    // 2: RATIO=4, keep 0101 -> A, C(last)
    exp4_q.push_back({1'b0, 4'hA});
    exp4_q.push_back({1'b1, 4'hC});
    send4(16'hDCBA, 4'b0101, 1'b1, nc);
    idle4();
    check_eq("t2_data_a", 32'(u4_m_data), 32'hA);
    check_eq("t2_last_a", 32'(u4_m_last), 32'd0);
    step();
    check_eq("t2_data_c", 32'(u4_m_data), 32'hC);
    check_eq("t2_last_c", 32'(u4_m_last), 32'd1);
    step();
    check_eq("t2_valid_end", 32'(u4_m_valid), 32'd0);
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
    check_eq("t2_u4_err", 32'(u4_err), 32'd1);
`endif
    drain(10);

    // 3: back-to-back {2,1},{4,3} -> 1,2,3,4 on consecutive cycles
    beat_cyc_q.delete();
    exp2_q.push_back({1'b0, 4'h1});
    exp2_q.push_back({1'b0, 4'h2});
    exp2_q.push_back({1'b0, 4'h3});
    exp2_q.push_back({1'b1, 4'h4});
    send2(8'h21, 2'b11, 1'b0, nc);
    send2(8'h43, 2'b11, 1'b1, nc);
    check_eq("t3_second_accept_cycles", 32'(nc), 32'd2);
    idle2();
    drain(20);
    check_eq("t3_beat_count", 32'(beat_cyc_q.size()), 32'd4);
    if (beat_cyc_q.size() == 4)
      check_eq("t3_no_gap", 32'(beat_cyc_q[3] - beat_cyc_q[0]), 32'd3);

    // 4: m_ready toggling; payload held during stalls, order preserved
    exp2_q.push_back({1'b0, 4'h5});
    exp2_q.push_back({1'b0, 4'h6});
    exp2_q.push_back({1'b0, 4'h7});
    exp2_q.push_back({1'b1, 4'h8});
    tog_on = 1'b1;
    u2_m_ready = 1'b0;
    fork
      begin
        while (tog_on) begin
          step();
          u2_m_ready = ~u2_m_ready;
        end
      end
      begin
        send2(8'h65, 2'b11, 1'b0, nc);
        send2(8'h87, 2'b11, 1'b1, nc);
        idle2();
        drain(40);
        tog_on = 1'b0;
      end
    join
    u2_m_ready = 1'b1;
    step();
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
    check_eq("t4_u2_err_clean", 32'(u2_err), 32'd0);
`endif

    // 5: keep 0, last=1 -> accepted in one cycle, no beat
    send2(8'hFF, 2'b00, 1'b1, nc);
    idle2();
    check_eq("t5_accept_cycles", 32'(nc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_no_valid", 32'(u2_m_valid), 32'd0);
      step();
    end
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
    check_eq("t5_u2_err", 32'(u2_err), 32'd1);
`endif

    // 6: reset during second beat of a 4-beat word
    exp4_q.push_back({1'b0, 4'h1});
    send4(16'h4321, 4'b1111, 1'b1, nc);
    idle4();
    check_eq("t6_data_1", 32'(u4_m_data), 32'h1);
    step();
    check_eq("t6_data_2", 32'(u4_m_data), 32'h2);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(u4_m_valid), 32'd0);
    check_eq("t6_rst_sready", 32'(u4_s_ready), 32'd0);
    check_eq("t6_rst_data", 32'(u4_m_data), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check_eq("t6_after_valid", 32'(u4_m_valid), 32'd0);
`ifdef STREAM_DOWNSIZE_KEEP_CHECK_EN
    check_eq("t6_u4_err_cleared", 32'(u4_err), 32'd0);
`endif
    exp4_q.push_back({1'b0, 4'h5});
    exp4_q.push_back({1'b0, 4'h6});
    exp4_q.push_back({1'b0, 4'h7});
    exp4_q.push_back({1'b1, 4'h8});
    send4(16'h8765, 4'b1111, 1'b1, nc);
    idle4();
    check_eq("t6_next_lane0", 32'(u4_m_data), 32'h5);
    drain(20);
    step();
    check_eq("t6_end_valid", 32'(u4_m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
